// File: rtl/rom_arbiter.sv
// Arbitrates the shared instruction ROM between fetch (I) and constant loads (D).
// Each access runs IDLE -> ACCESS -> RESP, with D priority bounded by a starvation counter.
module rom_arbiter #(
    parameter int DEPTH      = 4096,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    output logic        i_rerr,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_rerr,
    output logic        rom_en,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    localparam logic [31:0] LAST_ADDR = 32'(DEPTH - 4);
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    logic [1:0]    state;
    logic [CW-1:0] starve_cnt;
    logic          owner_d;
    logic          err_q;

    logic          d_win;
    logic          i_win;
    logic          grant;
    logic [31:0]   win_addr;
    logic          win_err;

    always_comb begin
        d_win    = d_req && (!i_req || (starve_cnt != STARVE_LIM));
        i_win    = i_req && !d_win;
        // Grants are suppressed while reset is asserted so every output reads 0.
        grant    = (state == IDLE) && !rst && (i_req || d_req);
        win_addr = d_win ? d_addr : i_addr;
        win_err  = (win_addr[1:0] != 2'b00) || (win_addr > LAST_ADDR);
    end

    assign i_gnt = grant && i_win;
    assign d_gnt = grant && d_win;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            owner_d    <= 1'b0;
            err_q      <= 1'b0;
            rom_en     <= 1'b0;
            rom_addr   <= 32'h0;
            i_rvalid   <= 1'b0;
            i_rdata    <= 32'h0;
            i_rerr     <= 1'b0;
            d_rvalid   <= 1'b0;
            d_rdata    <= 32'h0;
            d_rerr     <= 1'b0;
        end else begin
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            i_rerr   <= 1'b0;
            d_rerr   <= 1'b0;
            rom_en   <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        state   <= ACCESS;
                        owner_d <= d_win;
                        err_q   <= win_err;
                        // Faulting requests never reach the ROM; rom_addr keeps its old value.
                        if (!win_err) begin
                            rom_en   <= 1'b1;
                            rom_addr <= win_addr;
                        end
                        if (d_win && i_req) begin
                            starve_cnt <= starve_cnt + CW'(1);
                        end else if (i_win) begin
                            starve_cnt <= '0;
                        end
                    end
                end
                ACCESS: begin
                    state <= RESP;
                    if (owner_d) begin
                        d_rdata  <= err_q ? 32'h0 : rom_data;
                        d_rvalid <= 1'b1;
                        d_rerr   <= err_q;
                    end else begin
                        i_rdata  <= err_q ? 32'h0 : rom_data;
                        i_rvalid <= 1'b1;
                        i_rerr   <= err_q;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
